stream_pkt_limiter: RTL and testbench
=====================================

Name: stream_pkt_limiter

Overview:
Packet-length enforcer that sits directly upstream of stream_fifo on the ingress path. It accepts a valid/ready packet stream with a last flag, and passes packets of up to MAX_PKT_BEATS beats unchanged. Longer packets are cut: last is forced on beat MAX_PKT_BEATS and the remaining beats are discarded, so the downstream FIFO never sees a packet longer than its MAX_PKT_BEATS. Output is one full-throughput register stage.

Parameters:
DATA_WIDTH, 32, width of s_data/m_data (the packed user/keep/data word in the FIFO path)
MAX_PKT_BEATS, 4, maximum beats per output packet; legal range 1 and up

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
s_data  input  DATA_WIDTH  upstream data
s_last  input  1  upstream end-of-packet
s_valid  input  1  upstream valid
s_ready  output  1  upstream ready
m_data  output  DATA_WIDTH  downstream data
m_last  output  1  downstream end-of-packet (may be forced)
m_valid  output  1  downstream valid
m_ready  input  1  downstream ready
trunc_pulse  output  1  one-cycle pulse when a beat is accepted that forces last
pkt_count  output  32  packets emitted (only with STREAM_PKT_LIMITER_STATS_EN)
trunc_count  output  32  packets truncated (only with STREAM_PKT_LIMITER_STATS_EN)

Behaviour:
- Reset (rst=0, asynchronous): m_valid=0, m_last=0, m_data=0, trunc_pulse=0, state=PASS, beat_cnt=0, counters=0. s_ready=1 immediately after release.
- Handshake: a beat transfers when valid&&ready are high on a rising clk edge. m_valid/m_data/m_last are registered; a valid beat never changes or drops until it is accepted.
- Output stage: in PASS, s_ready = !m_valid || m_ready (full throughput, no combinational valid path). Latency is 1 cycle from s_ handshake to m_valid.
- beat_cnt: width $clog2(MAX_PKT_BEATS+1). Counts beats accepted in the current packet.
- State PASS, on an accepted beat:
  - s_last=1: emit the beat with m_last=1; beat_cnt<=0; stay in PASS.
  - s_last=0 and beat_cnt==MAX_PKT_BEATS-1: emit the beat with m_last forced to 1; trunc_pulse<=1 for one cycle; beat_cnt<=0; go to DISCARD.
  - Otherwise: emit the beat with m_last=0; beat_cnt++.
- State DISCARD: s_ready=1 regardless of the output stage. Accepted beats are dropped and never appear on m_. An accepted beat with s_last=1 returns the block to PASS. The output register can still drain while in DISCARD.
- A packet of exactly MAX_PKT_BEATS beats with s_last on the final beat is not truncated: no pulse, and the block stays in PASS.
- MAX_PKT_BEATS=1: every beat is emitted with m_last=1. Non-last beats cause truncation, and the following beats up to s_last are discarded.
- Simultaneous events: when the output stage is accepted and loaded with a new beat in the same cycle, the register is loaded and m_valid stays 1.
- Reset asserted mid-packet: all state clears. The first beat after release is treated as the start of a new packet.

Optional Feature:
STREAM_PKT_LIMITER_STATS_EN
- Defined:
  - pkt_count increments on each accepted upstream beat that is emitted with m_last=1 (natural or forced).
  - trunc_count increments together with trunc_pulse.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Not defined: the pkt_count/trunc_count ports and their registers are absent. trunc_pulse remains.

Test Plan:
- MAX=4, packet of 3 beats D0..D2 with last on D2, m_ready=1 -> identical 3 beats out, m_last on D2, each beat 1 cycle later, trunc_pulse never high.
- MAX=4, packet of 4 beats with last on beat 4 -> 4 beats out with m_last on beat 4, no truncation, state stays PASS.
- MAX=4, packet of 7 beats A0..A6, then a 2-beat packet B0..B1 -> out A0..A3 with m_last on A3, trunc_pulse once, A4..A6 consumed with s_ready=1 and not emitted, then B0..B1 intact; with stats, pkt_count=2 and trunc_count=1.
- Backpressure: 3-beat packet with m_ready low for 5 cycles after the first m_valid -> m_data/m_last held stable, s_ready=0 while the register is full, no loss or duplication, order preserved.
- MAX=1, packet of 3 beats -> 1 beat out with m_last=1, trunc_pulse=1, 2 beats discarded; a following single-beat packet passes with no pulse.
- rst driven low mid-packet (after beat 2 of a 6-beat packet), then a new 2-beat packet -> outputs clear asynchronously and the 2-beat packet passes intact with no truncation.

Source files
------------

// File: rtl/stream_pkt_limiter.sv
// Packet-length enforcer: passes packets up to MAX_PKT_BEATS beats, forces last and drops the tail of longer ones.
// Optional 32-bit saturating packet/truncation counters when STREAM_PKT_LIMITER_STATS_EN is defined.
module stream_pkt_limiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_BEATS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  trunc_pulse
`ifdef STREAM_PKT_LIMITER_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           trunc_count
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_BEATS - 1);

  typedef enum logic {PASS, DISCARD} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic                    last_p1;
  logic                    vld_p1;
  logic                    trunc_p1;

  logic accept;
  logic at_limit;
  logic ends_pkt;

  assign s_ready  = (state == DISCARD) ? 1'b1 : (!vld_p1 || m_ready);
  assign accept   = s_valid && s_ready;
  assign at_limit = (beat_cnt == CNT_LAST);
  assign ends_pkt = s_last || at_limit;

  assign m_data      = data_p1;
  assign m_last      = last_p1;
  assign m_valid     = vld_p1;
  assign trunc_pulse = trunc_p1;

  // Stage p1: output register, packet state and truncation decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= PASS;
      beat_cnt <= '0;
      data_p1  <= '0;
      last_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      trunc_p1 <= 1'b0;
    end else begin
      trunc_p1 <= 1'b0;
      if (vld_p1 && m_ready)
        vld_p1 <= 1'b0;
      if (accept) begin
        case (state)
          PASS: begin
            vld_p1  <= 1'b1;
            data_p1 <= s_data;
            last_p1 <= ends_pkt;
            if (s_last) begin
              beat_cnt <= '0;
            end else if (at_limit) begin
              beat_cnt <= '0;
              trunc_p1 <= 1'b1;
              state    <= DISCARD;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
          DISCARD: begin
            // Tail beats are swallowed; only the closing beat matters
            if (s_last)
              state <= PASS;
          end
          default: state <= PASS;
        endcase
      end
    end
  end

`ifdef STREAM_PKT_LIMITER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count   <= '0;
      trunc_count <= '0;
    end else if (accept && (state == PASS)) begin
      if (ends_pkt)
        pkt_count <= sat_inc(pkt_count);
      if (!s_last && at_limit)
        trunc_count <= sat_inc(trunc_count);
    end
  end
`endif

endmodule

// File: tb/tb_stream_pkt_limiter.sv
// Directed bench for stream_pkt_limiter: a MAX=4 instance and a MAX=1 instance on a shared clock/reset.
// Define STREAM_PKT_LIMITER_STATS_EN to also check the counters.
module tb_stream_pkt_limiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_ready = 1'b1;

  logic [31:0] s_data4 = '0, s_data1 = '0;
  logic        s_last4 = 1'b0, s_last1 = 1'b0;
  logic        s_valid4 = 1'b0, s_valid1 = 1'b0;
  logic        s_ready4, s_ready1;
  logic [31:0] m_data4, m_data1;
  logic        m_last4, m_last1;
  logic        m_valid4, m_valid1;
  logic        trunc_pulse4, trunc_pulse1;
`ifdef STREAM_PKT_LIMITER_STATS_EN
  logic [31:0] pkt_count4, trunc_count4, pkt_count1, trunc_count1;
`endif

  int nvec = 0;
  int nmis = 0;
  int np4 = 0;
  int np1 = 0;
  int base4, base1;
  logic [32:0] cap4[$];
  logic [32:0] cap1[$];
  logic [32:0] expq[$];
  logic        stall_q = 1'b0;
  logic [33:0] held = '0;

  always #5 clk = ~clk;

  stream_pkt_limiter #(.DATA_WIDTH(32), .MAX_PKT_BEATS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .s_data(s_data4), .s_last(s_last4), .s_valid(s_valid4), .s_ready(s_ready4),
    .m_data(m_data4), .m_last(m_last4), .m_valid(m_valid4), .m_ready(m_ready),
    .trunc_pulse(trunc_pulse4)
`ifdef STREAM_PKT_LIMITER_STATS_EN
    , .pkt_count(pkt_count4), .trunc_count(trunc_count4)
`endif
  );

  stream_pkt_limiter #(.DATA_WIDTH(32), .MAX_PKT_BEATS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_data(s_data1), .s_last(s_last1), .s_valid(s_valid1), .s_ready(s_ready1),
    .m_data(m_data1), .m_last(m_last1), .m_valid(m_valid1), .m_ready(m_ready),
    .trunc_pulse(trunc_pulse1)
`ifdef STREAM_PKT_LIMITER_STATS_EN
    , .pkt_count(pkt_count1), .trunc_count(trunc_count1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output capture, pulse counting and stall-stability check on the falling edge
  always @(negedge clk) begin
    if (m_valid4 && m_ready) cap4.push_back({m_last4, m_data4});
    if (m_valid1 && m_ready) cap1.push_back({m_last1, m_data1});
    if (trunc_pulse4) np4 <= np4 + 1;
    if (trunc_pulse1) np1 <= np1 + 1;
    if (stall_q) chk("hold", {30'd0, m_valid4, m_last4, m_data4}, {30'd0, held});
    stall_q <= m_valid4 && !m_ready;
    held    <= {m_valid4, m_last4, m_data4};
  end

  task automatic send(input int which, input logic [31:0] d, input logic l, input bit chk_disc);
    int n;
    @(negedge clk);
    if (which == 4) begin
      s_valid4 = 1'b1; s_data4 = d; s_last4 = l;
    end else begin
      s_valid1 = 1'b1; s_data1 = d; s_last1 = l;
    end
    if (chk_disc) chk("disc_sready", {63'd0, s_ready4}, 64'd1);
    n = 0;
    while (!((which == 4) ? s_ready4 : s_ready1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid4 = 1'b0; s_last4 = 1'b0;
    s_valid1 = 1'b0; s_last1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input int which);
    int ncap;
    ncap = (which == 4) ? cap4.size() : cap1.size();
    chk({tag, "_count"}, 64'(ncap), 64'(expq.size()));
    for (int i = 0; i < ncap && i < expq.size(); i++)
      chk(tag, 64'((which == 4) ? cap4[i] : cap1[i]), 64'(expq[i]));
    if (which == 4) cap4.delete(); else cap1.delete();
    expq.delete();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_mvalid", {63'd0, m_valid4}, 64'd0);
    chk("rst_mlast", {63'd0, m_last4}, 64'd0);
    chk("rst_mdata", 64'(m_data4), 64'd0);
    chk("rst_trunc", {63'd0, trunc_pulse4}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_sready", {63'd0, s_ready4}, 64'd1);
`ifdef STREAM_PKT_LIMITER_STATS_EN
    chk("rst_pkt", 64'(pkt_count4), 64'd0);
    chk("rst_trc", 64'(trunc_count4), 64'd0);
`endif

    // One-cycle latency on a single-beat packet
    send(4, 32'h0000_00AA, 1'b1, 1'b0);
    #1;
    chk("lat_mvalid", {63'd0, m_valid4}, 64'd1);
    chk("lat_mdata", 64'(m_data4), 64'h0000_00AA);
    chk("lat_mlast", {63'd0, m_last4}, 64'd1);
    idle();
    expq = '{{1'b1, 32'h0000_00AA}};
    check_out("lat", 4);

    // 3-beat packet passes unchanged
    base4 = np4;
    for (int i = 0; i < 3; i++) send(4, 32'h100 + i, i == 2, 1'b0);
    idle();
    expq = '{{1'b0, 32'h100}, {1'b0, 32'h101}, {1'b1, 32'h102}};
    check_out("p3", 4);
    chk("p3_pulse", 64'(np4 - base4), 64'd0);

    // Exactly MAX beats: no truncation
    base4 = np4;
    for (int i = 0; i < 4; i++) send(4, 32'h200 + i, i == 3, 1'b0);
    idle();
    expq = '{{1'b0, 32'h200}, {1'b0, 32'h201}, {1'b0, 32'h202}, {1'b1, 32'h203}};
    check_out("p4", 4);
    chk("p4_pulse", 64'(np4 - base4), 64'd0);

    // 7-beat packet truncated, tail discarded while the output is stalled, then a 2-beat packet
    base4 = np4;
    for (int i = 0; i < 4; i++) send(4, 32'hA0 + i, 1'b0, 1'b0);
    #1 m_ready = 1'b0;
    for (int i = 4; i < 7; i++) send(4, 32'hA0 + i, i == 6, 1'b1);
    #1 m_ready = 1'b1;
    send(4, 32'hB0, 1'b0, 1'b0);
    send(4, 32'hB1, 1'b1, 1'b0);
    idle();
    expq = '{{1'b0, 32'hA0}, {1'b0, 32'hA1}, {1'b0, 32'hA2}, {1'b1, 32'hA3},
             {1'b0, 32'hB0}, {1'b1, 32'hB1}};
    check_out("trunc", 4);
    chk("trunc_pulse", 64'(np4 - base4), 64'd1);
`ifdef STREAM_PKT_LIMITER_STATS_EN
    chk("trunc_pkt", 64'(pkt_count4), 64'd5);
    chk("trunc_trc", 64'(trunc_count4), 64'd1);
`endif

    // Backpressure: m_ready low for 5 cycles after first m_valid
    fork
      begin
        for (int i = 0; i < 3; i++) send(4, 32'hC0 + i, i == 2, 1'b0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (!m_valid4 && n < 50);
        if (n >= 50) chk("bp_timeout", 64'd1, 64'd0);
        m_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_sready", {63'd0, s_ready4}, 64'd0);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    idle();
    expq = '{{1'b0, 32'hC0}, {1'b0, 32'hC1}, {1'b1, 32'hC2}};
    check_out("bp", 4);

    // MAX=1: 3-beat packet truncated to one beat, then a single-beat packet
    base1 = np1;
    for (int i = 0; i < 3; i++) send(1, 32'hE0 + i, i == 2, 1'b0);
    idle();
    expq = '{{1'b1, 32'hE0}};
    check_out("m1_trunc", 1);
    chk("m1_pulse", 64'(np1 - base1), 64'd1);
    base1 = np1;
    send(1, 32'hF0, 1'b1, 1'b0);
    idle();
    expq = '{{1'b1, 32'hF0}};
    check_out("m1_single", 1);
    chk("m1_nopulse", 64'(np1 - base1), 64'd0);
`ifdef STREAM_PKT_LIMITER_STATS_EN
    chk("m1_pkt", 64'(pkt_count1), 64'd2);
    chk("m1_trc", 64'(trunc_count1), 64'd1);
`endif

    // Asynchronous reset after beat 2 of a 6-beat packet
    send(4, 32'hD0, 1'b0, 1'b0);
    send(4, 32'hD1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_mvalid", {63'd0, m_valid4}, 64'd0);
    chk("arst_mdata", 64'(m_data4), 64'd0);
    chk("arst_mlast", {63'd0, m_last4}, 64'd0);
    chk("arst_sready", {63'd0, s_ready4}, 64'd1);
`ifdef STREAM_PKT_LIMITER_STATS_EN
    chk("arst_pkt", 64'(pkt_count4), 64'd0);
`endif
    s_valid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expq = '{{1'b0, 32'hD0}};
    check_out("arst_pre", 4);
    base4 = np4;
    send(4, 32'h51, 1'b0, 1'b0);
    send(4, 32'h52, 1'b1, 1'b0);
    idle();
    expq = '{{1'b0, 32'h51}, {1'b1, 32'h52}};
    check_out("arst_post", 4);
    chk("arst_pulse", 64'(np4 - base4), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
